// File: rtl/rtclock_pkg.sv
// rtclock_pkg: shared constants and width helpers for the disciplined real-time clock.
package rtclock_pkg;

  localparam int unsigned NSEC_MODULO = 32'd1_000_000_000;
  localparam int unsigned NSEC_HALF   = 32'd500_000_000;

  // Increment is unsigned ns.frac with 16 integer-ns bits.
  function automatic int unsigned incr_width(input int unsigned frac_bits);
    return 16 + frac_bits;
  endfunction

  // PPS select width; a single input still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/rtclock_pps_sync.sv
// rtclock_pps_sync: PPS synchronisers, input select, select-change blanking, rising-edge
// detect and the loss-of-PPS counter.
module rtclock_pps_sync
  import rtclock_pkg::*;
#(
  parameter int unsigned N_PPS       = 2,
  parameter int unsigned LOST_CYCLES = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PPS-1:0]            pps,
  input  logic [sel_width(N_PPS)-1:0] pps_sel,
  output logic                        pps_edge,
  output logic                        pps_lost
);

  localparam int unsigned SEL_W = sel_width(N_PPS);

  logic [N_PPS-1:0] meta_q, sync_q;
  logic [SEL_W-1:0] sel_q, sel_idx;
  logic             sel_pps, prev_q, lost_q;
  logic [31:0]      cnt_q, cnt_d;

  // Out-of-range selects fall back to input 0.
  always_comb begin
    sel_idx = '0;
    if (32'(pps_sel) < N_PPS) sel_idx = pps_sel;
  end

  assign sel_pps = sync_q[sel_idx];

  // Blank for the cycle in which the select moves, so switching onto a high input is no edge.
  assign pps_edge = sel_pps & ~prev_q & (pps_sel == sel_q);

  // Cycles since the last edge, saturating at the loss threshold.
  always_comb begin
    cnt_d = cnt_q;
    if (pps_edge) begin
      cnt_d = '0;
    end else if (cnt_q < LOST_CYCLES) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Synchroniser chain, edge history and loss flag; loss is asserted out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      sel_q  <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      lost_q <= 1'b1;
    end else begin
      meta_q <= pps;
      sync_q <= meta_q;
      sel_q  <= pps_sel;
      prev_q <= sel_pps;
      cnt_q  <= cnt_d;
      lost_q <= pps_edge ? 1'b0 : (lost_q | (cnt_d >= LOST_CYCLES));
    end
  end

  assign pps_lost = lost_q;

endmodule

// File: rtl/rtclock_disc.sv
// rtclock_disc: disciplined {sec, nsec, frac} time-of-day with trimmable rate, absolute set,
// signed phase step and PPS alignment to the nearest second.
// Optional PPS edge timestamp capture is enabled by defining RTCLOCK_PPS_CAPTURE_EN.
module rtclock_disc
  import rtclock_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_NS = 8,
  parameter int unsigned FRAC_BITS     = 16,
  parameter int unsigned N_PPS         = 2,
  parameter int unsigned SEC_WIDTH     = 48,
  parameter int unsigned LOST_CYCLES   = 1_500_000_000 / CLK_PERIOD_NS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_PPS-1:0]                 pps,
  input  logic [sel_width(N_PPS)-1:0]      pps_sel,
  input  logic                             sync_en,
  input  logic                             incr_valid,
  input  logic [incr_width(FRAC_BITS)-1:0] incr,
  input  logic                             set_valid,
  input  logic [SEC_WIDTH-1:0]             set_sec,
  input  logic [29:0]                      set_nsec,
  input  logic                             step_valid,
  input  logic signed [31:0]               step_ns,
  output logic [SEC_WIDTH-1:0]             sec,
  output logic [29:0]                      nsec,
  output logic                             pps_err_valid,
  output logic signed [31:0]               pps_err,
  output logic                             pps_lost,
  output logic                             pps_ts_valid,
  output logic [SEC_WIDTH-1:0]             pps_ts_sec,
  output logic [29:0]                      pps_ts_nsec
);

  localparam int unsigned        INCR_W      = incr_width(FRAC_BITS);
  localparam int unsigned        ACC_W       = 30 + FRAC_BITS;
  localparam logic [29:0]        NSEC_MOD30  = 30'(NSEC_MODULO);
  localparam logic [ACC_W:0]     ACC_MOD     = {1'b0, NSEC_MOD30, {FRAC_BITS{1'b0}}};
  localparam logic signed [32:0] NSEC_MOD33  = 33'(NSEC_MODULO);
  localparam logic [31:0]        NSEC_HALF32 = 32'(NSEC_HALF);
  localparam logic [SEC_WIDTH-1:0] SEC_ONE   = SEC_WIDTH'(1);

  logic [INCR_W-1:0]    incr_q;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [SEC_WIDTH-1:0] sec_q, sec_d;
  logic [31:0]          err_q, err_d;
  logic                 err_valid_q, err_valid_d;

  logic [ACC_W:0]       sum;
  logic [ACC_W-1:0]     sum_wrapped, inc_acc;
  logic                 wrap, round_up, pps_edge;
  logic [SEC_WIDTH-1:0] inc_sec, step_sec;
  logic [29:0]          nsec_cur, inc_nsec, step_nsec;
  logic signed [32:0]   stepped;
  logic [31:0]          align_err;

  rtclock_pps_sync #(
    .N_PPS       (N_PPS),
    .LOST_CYCLES (LOST_CYCLES)
  ) u_pps_sync (
    .clk      (clk),
    .reset    (reset),
    .pps      (pps),
    .pps_sel  (pps_sel),
    .pps_edge (pps_edge),
    .pps_lost (pps_lost)
  );

  assign nsec_cur = acc_q[ACC_W-1:FRAC_BITS];

  // Nominal advance with one possible second wrap, then the phase step layered on top.
  always_comb begin
    sum         = {1'b0, acc_q} + {{(ACC_W + 1 - INCR_W){1'b0}}, incr_q};
    wrap        = (sum >= ACC_MOD);
    sum_wrapped = sum[ACC_W-1:0] - ACC_MOD[ACC_W-1:0];
    inc_acc     = wrap ? sum_wrapped : sum[ACC_W-1:0];
    inc_sec     = sec_q + SEC_WIDTH'(wrap);
    inc_nsec    = inc_acc[ACC_W-1:FRAC_BITS];
    stepped     = $signed({3'b000, inc_nsec}) + $signed({step_ns[31], step_ns});
    step_nsec   = stepped[29:0];
    step_sec    = inc_sec;
    if (stepped[32]) begin
      step_nsec = stepped[29:0] + NSEC_MOD30;
      step_sec  = inc_sec - SEC_ONE;
    end else if (stepped >= NSEC_MOD33) begin
      step_nsec = stepped[29:0] - NSEC_MOD30;
      step_sec  = inc_sec + SEC_ONE;
    end
  end

  // Round to the nearest second; the error is the signed local offset at the edge.
  always_comb begin
    round_up  = ({2'b00, nsec_cur} >= NSEC_HALF32);
    align_err = round_up ? ({2'b00, nsec_cur} - NSEC_MODULO) : {2'b00, nsec_cur};
  end

  // Command priority: set > alignment > step > increment; losers are dropped.
  always_comb begin
    acc_d       = inc_acc;
    sec_d       = inc_sec;
    err_d       = err_q;
    err_valid_d = 1'b0;
    if (set_valid) begin
      acc_d = {set_nsec, {FRAC_BITS{1'b0}}};
      sec_d = set_sec;
    end else if (pps_edge && sync_en) begin
      acc_d       = '0;
      sec_d       = round_up ? (sec_q + SEC_ONE) : sec_q;
      err_d       = align_err;
      err_valid_d = 1'b1;
    end else begin
      if (pps_edge) err_d = align_err;
      if (step_valid) begin
        acc_d = {step_nsec, inc_acc[FRAC_BITS-1:0]};
        sec_d = step_sec;
      end
    end
  end

  // Time-of-day, rate and PPS error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      incr_q      <= INCR_W'(CLK_PERIOD_NS) << FRAC_BITS;
      acc_q       <= '0;
      sec_q       <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
    end else begin
      if (incr_valid) incr_q <= incr;
      acc_q       <= acc_d;
      sec_q       <= sec_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign sec           = sec_q;
  assign nsec          = nsec_cur;
  assign pps_err       = err_q;
  assign pps_err_valid = err_valid_q;

`ifdef RTCLOCK_PPS_CAPTURE_EN
  logic                 ts_valid_q;
  logic [SEC_WIDTH-1:0] ts_sec_q;
  logic [29:0]          ts_nsec_q;

  // Capture the pre-alignment time on every detected edge, whatever sync_en says.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_valid_q <= 1'b0;
      ts_sec_q   <= '0;
      ts_nsec_q  <= '0;
    end else begin
      ts_valid_q <= pps_edge;
      if (pps_edge) begin
        ts_sec_q  <= sec_q;
        ts_nsec_q <= nsec_cur;
      end
    end
  end

  assign pps_ts_valid = ts_valid_q;
  assign pps_ts_sec   = ts_sec_q;
  assign pps_ts_nsec  = ts_nsec_q;
`else
  assign pps_ts_valid = 1'b0;
  assign pps_ts_sec   = '0;
  assign pps_ts_nsec  = '0;
`endif

endmodule

// File: tb/tb_rtclock_disc.sv
// tb_rtclock_disc: directed and randomized checks of rtclock_disc against a behavioural model
// that keeps time as (sec, fractional-ns) and derives PPS edges from an input history table.
module tb_rtclock_disc;

  localparam int unsigned LOST = 100;
  localparam longint      MODF = 64'd1_000_000_000 * 64'd65536;
  localparam int          HIST = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pps;
  logic        pps_sel;
  logic        sync_en, incr_valid, set_valid, step_valid;
  logic [31:0] incr;
  logic [47:0] set_sec;
  logic [29:0] set_nsec;
  logic [31:0] step_ns;
  logic [47:0] sec;
  logic [29:0] nsec;
  logic        pps_err_valid, pps_lost, pps_ts_valid;
  logic [31:0] pps_err;
  logic [47:0] pps_ts_sec;
  logic [29:0] pps_ts_nsec;

  rtclock_disc #(
    .LOST_CYCLES (LOST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pps           (pps),
    .pps_sel       (pps_sel),
    .sync_en       (sync_en),
    .incr_valid    (incr_valid),
    .incr          (incr),
    .set_valid     (set_valid),
    .set_sec       (set_sec),
    .set_nsec      (set_nsec),
    .step_valid    (step_valid),
    .step_ns       (step_ns),
    .sec           (sec),
    .nsec          (nsec),
    .pps_err_valid (pps_err_valid),
    .pps_err       (pps_err),
    .pps_lost      (pps_lost),
    .pps_ts_valid  (pps_ts_valid),
    .pps_ts_sec    (pps_ts_sec),
    .pps_ts_nsec   (pps_ts_nsec)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [47:0] m_sec;
  longint      m_fns;
  longint      m_incr;
  logic [31:0] m_err;
  logic        m_errv, m_lost, m_tsv;
  logic [47:0] m_ts_sec;
  logic [29:0] m_ts_nsec;
  logic [1:0]  pps_hist [HIST];
  logic        sel_hist [HIST];
  int          cyc, last_edge;
  bit          have_edge;
  int          n_checks, n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int hx(input int c);
    return c % HIST;
  endfunction

  function automatic logic [31:0] round_err(input longint n);
    return (n >= 500_000_000) ? 32'(n - 1_000_000_000) : 32'(n);
  endfunction

  // One clock of the model, using the inputs sampled at this rising edge.
  task automatic model_update();
    longint n, tot, q, r;
    logic   edge_now;
    pps_hist[hx(cyc)] = pps;
    sel_hist[hx(cyc)] = pps_sel;
    if (reset) begin
      // Cleared synchronisers: samples up to and including this cycle read as low.
      pps_hist[hx(cyc)]     = 2'b00;
      pps_hist[hx(cyc - 1)] = 2'b00;
      pps_hist[hx(cyc - 2)] = 2'b00;
      sel_hist[hx(cyc)]     = 1'b0;
      m_sec = '0; m_fns = 0; m_incr = 8 * 65536; m_err = '0; m_errv = 0;
      m_lost = 1; m_tsv = 0; m_ts_sec = '0; m_ts_nsec = '0; have_edge = 0;
    end else begin
      edge_now = (sel_hist[hx(cyc)] == sel_hist[hx(cyc - 1)]) &&
                 pps_hist[hx(cyc - 2)][sel_hist[hx(cyc)]] &&
                 !pps_hist[hx(cyc - 3)][sel_hist[hx(cyc - 1)]];
      n      = m_fns / 65536;
      m_errv = 0;
      m_tsv  = 0;
      if (edge_now) begin
        m_tsv = 1; m_ts_sec = m_sec; m_ts_nsec = 30'(n);
        have_edge = 1; last_edge = cyc;
      end
      if (set_valid) begin
        m_sec = set_sec;
        m_fns = longint'(set_nsec) * 65536;
      end else if (edge_now && sync_en) begin
        if (n >= 500_000_000) m_sec = m_sec + 48'd1;
        m_err  = round_err(n);
        m_fns  = 0;
        m_errv = 1;
      end else begin
        if (edge_now) m_err = round_err(n);
        tot = m_fns + m_incr + (step_valid ? longint'($signed(step_ns)) * 65536 : 0);
        q = tot / MODF;
        r = tot % MODF;
        if (r < 0) begin
          r += MODF;
          q -= 1;
        end
        m_sec = m_sec + 48'(q);
        m_fns = r;
      end
      if (incr_valid) m_incr = longint'(incr);
      m_lost = !have_edge || (cyc - last_edge >= int'(LOST));
    end
    cyc++;
  endtask

  task automatic check_all();
    check_eq("sec", 64'(sec), 64'(m_sec));
    check_eq("nsec", 64'(nsec), 64'(m_fns / 65536));
    check_eq("nsec_lt_1e9", 64'(nsec < 30'd1_000_000_000), 64'd1);
    check_eq("pps_err", {32'b0, pps_err}, {32'b0, m_err});
    check_eq("pps_err_valid", 64'(pps_err_valid), 64'(m_errv));
    check_eq("pps_lost", 64'(pps_lost), 64'(m_lost));
`ifdef RTCLOCK_PPS_CAPTURE_EN
    check_eq("pps_ts_valid", 64'(pps_ts_valid), 64'(m_tsv));
    check_eq("pps_ts_sec", 64'(pps_ts_sec), 64'(m_ts_sec));
    check_eq("pps_ts_nsec", 64'(pps_ts_nsec), 64'(m_ts_nsec));
`else
    check_eq("pps_ts_valid", 64'(pps_ts_valid), 64'd0);
    check_eq("pps_ts_sec", 64'(pps_ts_sec), 64'd0);
    check_eq("pps_ts_nsec", 64'(pps_ts_nsec), 64'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_set(input logic [47:0] s, input logic [29:0] ns);
    set_valid = 1'b1;
    set_sec   = s;
    set_nsec  = ns;
    tick();
    set_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < HIST; i++) begin
      pps_hist[i] = 2'b00;
      sel_hist[i] = 1'b0;
    end
    cyc = 3; last_edge = 0; have_edge = 0; n_checks = 0; n_fail = 0;
    reset = 1'b1; pps = 2'b00; pps_sel = 1'b0; sync_en = 1'b1;
    incr_valid = 1'b0; incr = '0; set_valid = 1'b0; set_sec = '0; set_nsec = '0;
    step_valid = 1'b0; step_ns = '0;

    // Reset state.
    ticks(3);
    check_eq("rst_sec", 64'(sec), 64'd0);
    check_eq("rst_nsec", 64'(nsec), 64'd0);
    check_eq("rst_lost", 64'(pps_lost), 64'd1);
    check_eq("rst_errv", 64'(pps_err_valid), 64'd0);
    reset = 1'b0;

    // Free run at 8 ns per cycle.
    ticks(10);
    check_eq("free_run_nsec", 64'(nsec), 64'd80);

    // Second rollover.
    do_set(48'd0, 30'd999_999_984);
    check_eq("set_visible", 64'(nsec), 64'd999_999_984);
    tick();
    check_eq("set_plus_incr", 64'(nsec), 64'd999_999_992);
    tick();
    check_eq("rollover_sec", 64'(sec), 64'd1);
    check_eq("rollover_nsec", 64'(nsec), 64'd0);

    // Fractional trim: 8.5 ns per cycle.
    incr_valid = 1'b1;
    incr       = 32'h0008_8000;
    do_set(48'd0, 30'd0);
    incr_valid = 1'b0;
    ticks(4);
    check_eq("frac_trim_nsec", 64'(nsec), 64'd34);
    incr_valid = 1'b1;
    incr       = 32'h0008_0000;
    tick();
    incr_valid = 1'b0;

    // Set then step, both directions.
    do_set(48'd5, 30'd999_999_990);
    step_valid = 1'b1;
    step_ns    = 32'd20;
    tick();
    step_valid = 1'b0;
    check_eq("step_pos_sec", 64'(sec), 64'd6);
    check_eq("step_pos_nsec", 64'(nsec), 64'd18);
    do_set(48'd6, 30'd500);
    step_valid = 1'b1;
    step_ns    = -32'sd1000;
    tick();
    step_valid = 1'b0;
    check_eq("step_neg_sec", 64'(sec), 64'd5);
    check_eq("step_neg_nsec", 64'(nsec), 64'd999_999_508);

    // Seconds wrap.
    do_set(48'hFFFF_FFFF_FFFF, 30'd999_999_992);
    tick();
    check_eq("sec_wrap", 64'(sec), 64'd0);

    // PPS rounding up: alignment sees nsec = 999 999 900.
    do_set(48'd7, 30'd999_999_884);
    pps = 2'b01;
    ticks(3);
    check_eq("align_up_valid", 64'(pps_err_valid), 64'd1);
    check_eq("align_up_err", {32'b0, pps_err}, {32'b0, 32'hFFFF_FF9C});
    check_eq("align_up_sec", 64'(sec), 64'd8);
    check_eq("align_up_nsec", 64'(nsec), 64'd0);
    tick();
    check_eq("align_pulse_once", 64'(pps_err_valid), 64'd0);
    pps = 2'b00;
    ticks(4);

    // PPS rounding down: alignment sees nsec = 300.
    do_set(48'd8, 30'd284);
    pps = 2'b01;
    ticks(3);
    check_eq("align_dn_err", {32'b0, pps_err}, 64'd300);
    check_eq("align_dn_sec", 64'(sec), 64'd8);
    check_eq("align_dn_nsec", 64'(nsec), 64'd0);
    pps = 2'b00;
    ticks(4);

    // Set coinciding with an edge wins.
    pps = 2'b01;
    ticks(2);
    do_set(48'd3, 30'd777);
    check_eq("coinc_errv", 64'(pps_err_valid), 64'd0);
    check_eq("coinc_nsec", 64'(nsec), 64'd777);
    pps = 2'b00;
    ticks(4);

    // Switching onto an input that is already high is not an edge.
    pps = 2'b10;
    ticks(4);
    pps_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("sel_switch_no_edge", 64'(pps_err_valid), 64'd0);
    end
    pps = 2'b00;
    ticks(4);
    pps = 2'b10;
    ticks(3);
    check_eq("sel1_edge", 64'(pps_err_valid), 64'd1);
    check_eq("sel1_lost_clear", 64'(pps_lost), 64'd0);

    // Loss after LOST cycles, cleared by the next edge.
    pps = 2'b00;
    ticks(99);
    check_eq("lost_before", 64'(pps_lost), 64'd0);
    tick();
    check_eq("lost_after", 64'(pps_lost), 64'd1);
    pps = 2'b10;
    ticks(3);
    check_eq("lost_cleared", 64'(pps_lost), 64'd0);
    pps = 2'b00;
    pps_sel = 1'b0;
    ticks(4);

    // Reset mid-operation.
    reset = 1'b1;
    ticks(2);
    check_eq("mid_rst_sec", 64'(sec), 64'd0);
    check_eq("mid_rst_lost", 64'(pps_lost), 64'd1);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 999) == 0);
      set_valid  = ($urandom_range(0, 149) == 0);
      set_sec    = {16'($urandom), $urandom};
      set_nsec   = 30'($urandom_range(0, 999_999_999));
      step_valid = ($urandom_range(0, 19) == 0);
      step_ns    = 32'($urandom_range(0, 1_999_999_998)) - 32'd999_999_999;
      incr_valid = ($urandom_range(0, 99) == 0);
      incr       = {16'($urandom_range(4, 12)), 16'($urandom)};
      if ($urandom_range(0, 39) == 0) pps[0] = ~pps[0];
      if ($urandom_range(0, 39) == 0) pps[1] = ~pps[1];
      if ($urandom_range(0, 199) == 0) pps_sel = ~pps_sel;
      if ($urandom_range(0, 299) == 0) sync_en = ~sync_en;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
